// File: rtl/sn_stream_decoder.sv
// ---------------------------------------------------------------------------
// sn_stream_decoder
//
// Purpose:
//   Converts a serial stochastic bitstream back to binary. The block counts
//   the ones seen over a window of 2^WIN_LOG2 enabled samples. When a window
//   completes, it publishes three results:
//     - the raw ones count;
//     - a unipolar or bipolar binary value;
//     - an exponential moving average of the unipolar value, scaled to OUT_W
//       bits.
//   A one-cycle valid pulse marks each completed window. The published
//   outputs are registered at the end of that REPORT cycle and then held
//   until the next REPORT.
//
// Parameters:
//   WIN_LOG2   log2 of the window length N (2..8)
//   OUT_W      width of the averaged output (> WIN_LOG2)
//   EMA_SHIFT  smoothing shift, alpha = 2^-EMA_SHIFT (0..OUT_W-1)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous reset, active-low
//   sn_bit      stochastic bitstream input, sampled when en=1 in ACCUM
//   en          sample enable; low freezes all counters
//   start       begins a window from IDLE; ignored elsewhere
//   cont        continuous mode; sampled in REPORT to auto-restart
//   bipolar     result encoding select; sampled in REPORT
//   busy        high in ACCUM and REPORT
//   valid       one-cycle pulse in REPORT
//   count_out   ones count of the last window (0..N)
//   result_out  unipolar: count zero-extended; bipolar: 2*count-N
//   avg_out     moving average of the scaled unipolar value
// ---------------------------------------------------------------------------
module sn_stream_decoder #(
    parameter int WIN_LOG2  = 4,
    parameter int OUT_W     = 8,
    parameter int EMA_SHIFT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sn_bit,
    input  logic                  en,
    input  logic                  start,
    input  logic                  cont,
    input  logic                  bipolar,
    output logic                  busy,
    output logic                  valid,
    output logic [WIN_LOG2:0]     count_out,
    output logic [WIN_LOG2+1:0]   result_out,
    output logic [OUT_W-1:0]      avg_out
);

    localparam int SCALE_SHIFT = OUT_W - WIN_LOG2;

    // A completely full window (all ones) is the only count with the top bit set.
    localparam logic [WIN_LOG2:0]   FULL_CNT  = {1'b1, {WIN_LOG2{1'b0}}};
    // N expressed in the result width, used as the bipolar offset.
    localparam logic [WIN_LOG2+1:0] N_RESULT  = {2'b01, {WIN_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [WIN_LOG2:0]     onesCnt_q, onesCnt_d;
    logic [WIN_LOG2-1:0]   sampCnt_q, sampCnt_d;
    logic [WIN_LOG2:0]     countOut_q, countOut_d;
    logic [WIN_LOG2+1:0]   resultOut_q, resultOut_d;
    logic [OUT_W-1:0]      avgOut_q, avgOut_d;
    logic                  firstFlag_q, firstFlag_d;

    logic [OUT_W-1:0]      scaled;
    logic signed [OUT_W:0] emaDiff;
    logic signed [OUT_W:0] emaStep;
    logic [OUT_W:0]        emaSum;

    // State and counter registers; reset drops any partial window at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            onesCnt_q <= '0;
            sampCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            onesCnt_q <= onesCnt_d;
            sampCnt_q <= sampCnt_d;
        end
    end

    // Next-state and counter logic. The counters are cleared whenever they are
    // not accumulating, so every window starts from zero. This holds both for
    // a start from IDLE and for a continuous-mode restart out of REPORT.
    always_comb begin
        state_d   = state_q;
        onesCnt_d = onesCnt_q;
        sampCnt_d = sampCnt_q;
        unique case (state_q)
            IDLE: begin
                onesCnt_d = '0;
                sampCnt_d = '0;
                if (start) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (en) begin
                    sampCnt_d = sampCnt_q + 1'b1;
                    onesCnt_d = onesCnt_q + {{WIN_LOG2{1'b0}}, sn_bit};
                    // The sample counter is all ones exactly on the N-th sample.
                    if (sampCnt_q == '1) begin
                        state_d = REPORT;
                    end
                end
            end
            REPORT: begin
                onesCnt_d = '0;
                sampCnt_d = '0;
                state_d   = cont ? ACCUM : IDLE;
            end
            default: begin
                state_d   = IDLE;
                onesCnt_d = '0;
                sampCnt_d = '0;
            end
        endcase
    end

    // Scaling and moving-average datapath, all fed from the held window count.
    // A full window would scale to exactly 2^OUT_W. Its low bits come out as
    // zero, so that case is forced to the largest representable value instead.
    // The average step is a signed difference with an arithmetic shift. The
    // step never overshoots the target, so the sum stays in 0..2^OUT_W-1.
    always_comb begin
        scaled  = {onesCnt_q[WIN_LOG2-1:0], {SCALE_SHIFT{1'b0}}};
        if (onesCnt_q == FULL_CNT) begin
            scaled = '1;
        end
        emaDiff = $signed({1'b0, scaled}) - $signed({1'b0, avgOut_q});
        emaStep = emaDiff >>> EMA_SHIFT;
        emaSum  = {1'b0, avgOut_q} + emaStep;
    end

    // Output register next values. They only change while in REPORT, which
    // makes every result hold between windows.
    always_comb begin
        countOut_d  = countOut_q;
        resultOut_d = resultOut_q;
        avgOut_d    = avgOut_q;
        firstFlag_d = firstFlag_q;
        if (state_q == REPORT) begin
            countOut_d  = onesCnt_q;
            resultOut_d = bipolar ? ({onesCnt_q, 1'b0} - N_RESULT)
                                  : {1'b0, onesCnt_q};
            if (firstFlag_q) begin
                avgOut_d = scaled;
            end else begin
                // The MSB of the sum cannot be set. This guard keeps the
                // register provably inside its range.
                avgOut_d = emaSum[OUT_W] ? '1 : emaSum[OUT_W-1:0];
            end
            firstFlag_d = 1'b0;
        end
    end

    // Published result registers. The first window after reset loads the
    // average directly instead of blending it with the reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            countOut_q  <= '0;
            resultOut_q <= '0;
            avgOut_q    <= '0;
            firstFlag_q <= 1'b1;
        end else begin
            countOut_q  <= countOut_d;
            resultOut_q <= resultOut_d;
            avgOut_q    <= avgOut_d;
            firstFlag_q <= firstFlag_d;
        end
    end

    assign busy       = (state_q == ACCUM) || (state_q == REPORT);
    assign valid      = (state_q == REPORT);
    assign count_out  = countOut_q;
    assign result_out = resultOut_q;
    assign avg_out    = avgOut_q;

endmodule

// File: tb/tb_sn_stream_decoder.sv
// ---------------------------------------------------------------------------
// tb_sn_stream_decoder
//
// Drives complete windows into sn_stream_decoder (WIN_LOG2=4, OUT_W=8,
// EMA_SHIFT=2). Each time a window is driven, its expected result is pushed
// onto a queue. A monitor pops one entry per valid pulse and compares it
// with the outputs registered at the end of REPORT.
// ---------------------------------------------------------------------------
module tb_sn_stream_decoder;

    localparam int WIN_LOG2  = 4;
    localparam int OUT_W     = 8;
    localparam int EMA_SHIFT = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 sn_bit;
    logic                 en;
    logic                 start;
    logic                 cont;
    logic                 bipolar;
    logic                 busy;
    logic                 valid;
    logic [WIN_LOG2:0]    count_out;
    logic [WIN_LOG2+1:0]  result_out;
    logic [OUT_W-1:0]     avg_out;

    typedef struct {
        logic [4:0] count;
        logic [5:0] result;
        logic [7:0] avg;
    } expect_t;

    expect_t expQ[$];
    expect_t lastExp;
    expect_t monEntry;
    int      assertCount = 0;
    int      failCount   = 0;
    int      modelAvg    = 0;
    bit      modelFirst  = 1'b1;

    sn_stream_decoder #(
        .WIN_LOG2  (WIN_LOG2),
        .OUT_W     (OUT_W),
        .EMA_SHIFT (EMA_SHIFT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sn_bit     (sn_bit),
        .en         (en),
        .start      (start),
        .cont       (cont),
        .bipolar    (bipolar),
        .busy       (busy),
        .valid      (valid),
        .count_out  (count_out),
        .result_out (result_out),
        .avg_out    (avg_out)
    );

    always #5 clk = ~clk;

    // Single comparison point for every check.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Reference model: ones count, encoding and the moving average. The
    // average uses integer floor division rather than shifts.
    function automatic expect_t predict(input logic [15:0] bits, input logic bip);
        expect_t e;
        int cnt;
        int scaledV;
        int diff;
        int step;
        cnt = $countones(bits);
        e.count  = 5'(cnt);
        e.result = bip ? 6'(2 * cnt - 16) : 6'(cnt);
        scaledV  = (cnt == 16) ? 255 : cnt * 16;
        if (modelFirst) begin
            modelAvg = scaledV;
        end else begin
            diff = scaledV - modelAvg;
            step = (diff >= 0) ? (diff / 4) : -((-diff + 3) / 4);
            modelAvg = modelAvg + step;
        end
        modelFirst = 1'b0;
        e.avg = 8'(modelAvg);
        return e;
    endfunction

    // Scoreboard monitor: one expected entry per valid pulse. The data is
    // checked after the REPORT edge registers it. Valid must drop after one
    // cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedValid", 32'd1, 32'd0);
                end else begin
                    monEntry = expQ.pop_front();
                    @(posedge clk);
                    #1;
                    checkOutput("countOut", 32'(count_out), 32'(monEntry.count));
                    checkOutput("resultOut", 32'(result_out), 32'(monEntry.result));
                    checkOutput("avgOut", 32'(avg_out), 32'(monEntry.avg));
                    lastExp = monEntry;
                    @(negedge clk);
                    checkOutput("validPulse", 32'(valid), 32'd0);
                end
            end
        end
    end

    // Asynchronous reset: outputs must clear without a clock edge.
    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstValid", 32'(valid), 32'd0);
        checkOutput("rstCount", 32'(count_out), 32'd0);
        checkOutput("rstResult", 32'(result_out), 32'd0);
        checkOutput("rstAvg", 32'(avg_out), 32'd0);
        en      = 1'b0;
        start   = 1'b0;
        sn_bit  = 1'b0;
        cont    = 1'b0;
        bipolar = 1'b0;
        expQ.delete();
        modelFirst = 1'b1;
        modelAvg   = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one window of 16 enabled samples. Optional features:
    //   - a start pulse from IDLE;
    //   - idle en=0 cycles between samples, with sn_bit high;
    //   - stray start pulses mid-window and during REPORT.
    task automatic applyStimulus(input logic [15:0] bits, input logic bip,
                                 input logic contMode, input logic doStart,
                                 input logic sparse, input logic pokeStart);
        bipolar = bip;
        cont    = contMode;
        expQ.push_back(predict(bits, bip));
        if (doStart) begin
            @(posedge clk);
            #1;
            start = 1'b1;
            en    = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            if (sparse) begin
                @(posedge clk);
                #1;
                start  = 1'b0;
                en     = 1'b0;
                sn_bit = 1'b1;
            end
            @(posedge clk);
            #1;
            start  = pokeStart && (i == 5);
            en     = 1'b1;
            sn_bit = bits[i];
            if (i == 15) begin
                @(negedge clk);
                checkOutput("validEarly", 32'(valid), 32'd0);
            end
        end
        @(posedge clk);
        #1;
        en     = 1'b0;
        sn_bit = 1'b0;
        start  = pokeStart;
        @(negedge clk);
        checkOutput("validLatency", 32'(valid), 32'd1);
        checkOutput("busyReport", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDrain();
        for (int k = 0; k < 8 && expQ.size() != 0; k++) begin
            @(posedge clk);
        end
        checkOutput("scoreboardDrain", 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n   = 1'b1;
        en      = 1'b0;
        start   = 1'b0;
        sn_bit  = 1'b0;
        cont    = 1'b0;
        bipolar = 1'b0;
        #12;

        // All ones, unipolar: count saturates at N, average loads 255.
        doReset();
        applyStimulus(16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        waitDrain();
        checkOutput("busyIdle1", 32'(busy), 32'd0);

        // All zeros, bipolar: result is -N.
        doReset();
        applyStimulus(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        waitDrain();

        // Continuous mode: alternating window then all ones, no idle gap.
        doReset();
        applyStimulus(16'h5555, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("busyCont", 32'(busy), 32'd1);
        applyStimulus(16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        waitDrain();
        checkOutput("busyIdle3", 32'(busy), 32'd0);

        // Sparse enable: ten ones over sixteen enabled samples.
        doReset();
        applyStimulus(16'hB6D3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        waitDrain();

        // Reset mid-window after seven samples, then a clean full window.
        @(posedge clk);
        #1;
        start = 1'b1;
        en    = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            en     = 1'b1;
            sn_bit = 1'b1;
            @(posedge clk);
            #1;
        end
        checkOutput("busyMid", 32'(busy), 32'd1);
        #2;
        doReset();
        applyStimulus(16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        waitDrain();

        // Stray start pulses in ACCUM and REPORT: no restart, outputs hold.
        applyStimulus(16'h9A3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        waitDrain();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("busyHold", 32'(busy), 32'd0);
        end
        checkOutput("holdCount", 32'(count_out), 32'(lastExp.count));
        checkOutput("holdResult", 32'(result_out), 32'(lastExp.result));
        checkOutput("holdAvg", 32'(avg_out), 32'(lastExp.avg));

        // A few random windows continue the moving average.
        for (int r = 0; r < 3; r++) begin
            applyStimulus(16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b1,
                          1'($urandom_range(0, 1)), 1'b0);
            waitDrain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
